// File: rtl/multiplier_arbiter.sv
// multiplier_arbiter: round-robin sharing of one registered multiplier
// among NumReq valid/ready requesters, with a tagged response channel.
module multiplier_arbiter #(
  parameter  int Width   = 8,
  parameter  int NumReq  = 4,
  localparam int IdWidth = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_a_i,
  input  logic [NumReq*Width-1:0] req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [2*Width-1:0]      rsp_prod_o,
  output logic [IdWidth-1:0]      rsp_id_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   ptr_q, ptr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [Width-1:0]     a_q, a_d;
  logic [Width-1:0]     b_q, b_d;
  logic [2*Width-1:0]   prod_q, prod_d;
  logic [2*Width-1:0]   mul;
  logic [IdWidth-1:0]   gnt_idx;
  logic                 gnt_found;

  // Multiplier array, fed only from the operand registers
  assign mul = {{Width{1'b0}}, a_q} * {{Width{1'b0}}, b_q};

  // Round-robin search: first valid at or above ptr, with wrap
  always_comb begin
    int c;
    c         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      c = int'(ptr_q) + i;
      if (c >= NumReq) c = c - NumReq;
      if (!gnt_found && req_valid_i[c]) begin
        gnt_found = 1'b1;
        gnt_idx   = IdWidth'(c);
      end
    end
  end

  // Next state, operand capture and grant strobes
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    prod_d      = prod_q;
    req_ready_o = '0;
    unique case (state_q)
      IDLE: begin
        // ready stays low while reset is held
        if (rst_ni && gnt_found) begin
          req_ready_o[gnt_idx] = 1'b1;
          a_d     = req_a_i[int'(gnt_idx)*Width +: Width];
          b_d     = req_b_i[int'(gnt_idx)*Width +: Width];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IdWidth'(NumReq - 1)) ?
                    '0 : gnt_idx + IdWidth'(1);
          state_d = CALC;
        end
      end
      CALC: begin
        prod_d  = mul;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_prod_o  = prod_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb_multiplier_arbiter: directed and random checks of the shared
// multiplier arbiter against a behavioural model.
`timescale 1ns/1ps
module tb_multiplier_arbiter;
  localparam int W = 8, N = 4, IW = 2;
  localparam int W2 = 5, N2 = 3, IW2 = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    ready;
  logic [N*W-1:0]  a_bus = '0, b_bus = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [2*W-1:0]  prod;
  logic [IW-1:0]   id;
  logic            busy;

  logic [N2-1:0]   v2 = '0;
  logic [N2-1:0]   r2;
  logic [N2*W2-1:0] a2 = '0, b2 = '0;
  logic            rv2;
  logic            rr2 = 1'b1;
  logic [2*W2-1:0] p2;
  logic [IW2-1:0]  id2;
  logic            busy2;

  always #5 clk = ~clk;

  multiplier_arbiter #(.Width(W), .NumReq(N)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready),
    .req_a_i(a_bus), .req_b_i(b_bus),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_prod_o(prod), .rsp_id_o(id), .busy_o(busy)
  );

  multiplier_arbiter #(.Width(W2), .NumReq(N2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v2), .req_ready_o(r2),
    .req_a_i(a2), .req_b_i(b2),
    .rsp_valid_o(rv2), .rsp_ready_i(rr2),
    .rsp_prod_o(p2), .rsp_id_o(id2), .busy_o(busy2)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester side: per-requester FIFOs of pending operand pairs
  logic [W-1:0] qa [N][$];
  logic [W-1:0] qb [N][$];
  logic [N-1:0] acc = '0;
  int n_push = 0, n_acc = 0, n_rsp = 0, n_drop = 0;
  bit rnd_mode = 1'b0;

  task automatic push(input int k, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    qa[k].push_back(a);
    qb[k].push_back(b);
    n_push++;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      valid[k] = (qa[k].size() != 0);
      a_bus[k*W +: W] = valid[k] ? qa[k][0] : '0;
      b_bus[k*W +: W] = valid[k] ? qb[k][0] : '0;
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N; k++)
      if (acc[k] && qa[k].size() != 0) begin
        void'(qa[k].pop_front());
        void'(qb[k].pop_front());
      end
    acc = '0;
    drive();
    if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
  end

  // Behavioural model: one transaction in flight, rr pointer as integer
  int phase = 0, mptr = 0, eid = 0;
  logic [2*W-1:0] eprod = '0;
  int glog[$], rlog[$];
  logic [2*W-1:0] plog[$];

  always @(negedge clk) begin
    logic [N-1:0] er;
    logic [2*W-1:0] ta, tb;
    int g;
    er = '0;
    g = -1;
    if (!rst_n) begin
      if (phase != 0) n_drop++;
      phase = 0;
      mptr  = 0;
      chk("rst_ready", ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prod", prod, 0);
      chk("rst_id", id, 0);
    end else begin
      if (phase == 0)
        for (int i = 0; i < N; i++)
          if (g < 0 && valid[(mptr + i) % N]) g = (mptr + i) % N;
      if (g >= 0) er[g] = 1'b1;
      chk("ready", ready, er);
      chk("busy", busy, phase != 0);
      chk("rsp_valid", rsp_valid, phase == 2);
      if (phase == 2) begin
        chk("prod", prod, eprod);
        chk("id", id, eid);
      end
      case (phase)
        0: if (g >= 0) begin
          ta = (2*W)'(a_bus[g*W +: W]);
          tb = (2*W)'(b_bus[g*W +: W]);
          eprod = ta * tb;
          eid = g;
          glog.push_back(g);
          acc[g] = 1'b1;
          mptr = (g + 1) % N;
          n_acc++;
          phase = 1;
        end
        1: phase = 2;
        default: if (rsp_ready) begin
          rlog.push_back(eid);
          plog.push_back(prod);
          n_rsp++;
          phase = 0;
        end
      endcase
    end
  end

  // Second instance: narrow operands, three requesters, random traffic
  bit en2 = 1'b0;
  logic [N2-1:0] acc2 = '0, pend2 = '0;
  logic [2*W2-1:0] exp2 [N2];
  int sent2 = 0, got2 = 0;

  always @(posedge clk) begin
    #1;
    for (int k = 0; k < N2; k++) begin
      if (acc2[k]) begin
        v2[k] = 1'b0;
        acc2[k] = 1'b0;
      end
      if (!v2[k] && en2 && $urandom_range(0, 2) == 0) begin
        a2[k*W2 +: W2] = W2'($urandom);
        b2[k*W2 +: W2] = W2'($urandom);
        v2[k] = 1'b1;
        sent2++;
      end
    end
    rr2 = en2 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (rst_n) begin
    logic [2*W2-1:0] xa, xb;
    for (int k = 0; k < N2; k++)
      if (v2[k] && r2[k]) begin
        xa = (2*W2)'(a2[k*W2 +: W2]);
        xb = (2*W2)'(b2[k*W2 +: W2]);
        exp2[k] = xa * xb;
        pend2[k] = 1'b1;
        acc2[k] = 1'b1;
      end
    if (rv2 && rr2) begin
      chk("w5_prod", p2, exp2[id2]);
      chk("w5_tag", pend2[id2], 1);
      pend2[id2] = 1'b0;
      got2++;
    end
  end

  task automatic wait_rsps(input int target, input string nm);
    int c;
    c = 0;
    while (n_rsp < target && c < 3000) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk({nm, "_done"}, n_rsp >= target, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int b, c;
    logic [2*W-1:0] held;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // T1: single request, latency and literal product
    @(negedge clk);
    rsp_ready = 1'b1;
    push(0, 8'h0F, 8'h0F);
    c = 0;
    while (ready == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("t1_ready0", ready, 4'b0001);
    @(negedge clk);
    chk("t1_calc_valid", rsp_valid, 0);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_prod", prod, 16'h00E1);
    chk("t1_id", id, 0);
    wait_rsps(1, "t1");

    // T2: all four valid, rr order 0,1,2,3,0
    do_reset();
    b = glog.size();
    for (int k = 0; k < N; k++) push(k, 8'(k), 8'(2*k));
    push(0, 8'd0, 8'd0);
    wait_rsps(n_rsp + 5, "t2");
    chk("t2_g0", glog[b], 0);
    chk("t2_g1", glog[b+1], 1);
    chk("t2_g2", glog[b+2], 2);
    chk("t2_g3", glog[b+3], 3);
    chk("t2_g4", glog[b+4], 0);
    chk("t2_p1", plog[b+1], 2);
    chk("t2_p2", plog[b+2], 8);
    chk("t2_p3", plog[b+3], 18);
    chk("t2_r3", rlog[b+3], 3);

    // T3: all-ones and zero operands
    b = plog.size();
    push(3, 8'hFF, 8'hFF);
    wait_rsps(n_rsp + 1, "t3a");
    push(1, 8'h00, 8'hAB);
    wait_rsps(n_rsp + 1, "t3b");
    chk("t3_p_ff", plog[b], 16'hFE01);
    chk("t3_id_ff", rlog[b], 3);
    chk("t3_p_zero", plog[b+1], 0);
    chk("t3_id_zero", rlog[b+1], 1);

    // T4: stalled response with every requester waiting
    rsp_ready = 1'b0;
    for (int k = 0; k < N; k++) push(k, 8'(k + 1), 8'd3);
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    held = prod;
    chk("t4_first_prod", prod, 9);
    chk("t4_first_id", id, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_prod", prod, held);
      chk("t4_busy", busy, 1);
      chk("t4_no_ready", ready, 0);
    end
    rsp_ready = 1'b1;
    wait_rsps(n_rsp + 4, "t4");

    // T5: reset during CALC drops the transaction, ptr returns to 0
    push(2, 8'd5, 8'd6);
    c = 0;
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy0", busy, 0);
    chk("t5_valid0", rsp_valid, 0);
    chk("t5_prod0", prod, 0);
    chk("t5_ready0", ready, 0);
    push(3, 8'd7, 8'd7);
    push(0, 8'd2, 8'd9);
    b = glog.size();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_rsps(n_rsp + 2, "t5");
    chk("t5_first_grant", glog[b], 0);
    chk("t5_second_grant", glog[b+1], 3);
    chk("t5_drops", n_drop, 1);

    // T6: random traffic on both instances
    rnd_mode = 1'b1;
    en2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push($urandom_range(0, N - 1), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    en2 = 1'b0;
    wait_rsps(n_push - n_drop, "t6");
    rnd_mode = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_w5_count", got2, sent2);
    chk("t6_w5_pending", pend2, 0);
    chk("no_lost", n_rsp + n_drop, n_push);
    chk("accepted", n_acc, n_push);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
